sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_if.sv | 43 ++++
 rtl/sram_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_ctrl_if
//   Host-side bundle of the SRAM controller. The memory-side pins (address,
//   strobes and the bidirectional data bus) stay plain ports on the controller.
//
//   Handshake (single rule for the whole block):
//     The host raises req with we/addrIn/wdata valid. The controller takes them
//     only at a clock edge where it is idle (busy=0). While busy=1 the request
//     is ignored and not queued. Completion is a single-cycle ack pulse. For a
//     read, rdata is valid from the ack cycle until the next read completes.
//     A req held high during the ack cycle starts the next access immediately.
//
//   Signals:
//     req, we, addrIn, wdata     host -> controller
//     ack, busy, rdata, verifyErr controller -> host
//     dbg_state                  current FSM state encoding (observation only)
//     dbg_drive                  controller is driving the SRAM data bus
// -----------------------------------------------------------------------------
interface sram_ctrl_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addrIn;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic                  busy;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  verifyErr;
    logic [2:0]            dbg_state;
    logic                  dbg_drive;

    modport master (
        output req, we, addrIn, wdata,
        input  ack, busy, rdata, verifyErr, dbg_state, dbg_drive
    );

    modport slave (
        input  req, we, addrIn, wdata,
        output ack, busy, rdata, verifyErr, dbg_state, dbg_drive
    );
endinterface

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//   Asynchronous-SRAM access sequencer. One access at a time runs through the
//   phases SETUP -> PULSE -> HOLD, each lasting a parameterised number of
//   clock cycles, then returns to IDLE and pulses ack for one cycle.
//
//   Optional feature, selected by the macro SRAM_CTRL_VERIFY_EN:
//     every write is followed by TURN (one cycle, bus released, strobes high,
//     chip still selected) and VCHK (PULSE_CYCLES cycles reading the location
//     back). verifyErr is loaded with the comparison result in the ack cycle.
//     Without the macro verifyErr is tied low and writes finish after HOLD.
//
//   Parameters:
//     DATA_WIDTH    data word width
//     ADDR_WIDTH    SRAM address width
//     SETUP_CYCLES  cycles of address/data setup before the strobe (>= 1)
//     PULSE_CYCLES  cycles of notWE/notOE low (>= 1)
//     HOLD_CYCLES   cycles of address/data hold after the strobe (>= 1)
//
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset
//     host      sram_ctrl_if.slave: req/we/addrIn/wdata in,
//               ack/busy/rdata/verifyErr/dbg_state/dbg_drive out
//     memAddr   SRAM address (last latched address, 0 after reset)
//     memData   SRAM bidirectional data bus
//     notOE     active-low output enable
//     notWE     active-low write enable
//     notCS     active-low chip select
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_ctrl_if.slave            host,
    output logic [ADDR_WIDTH-1:0] memAddr,
    inout  wire  [DATA_WIDTH-1:0] memData,
    output logic                  notOE,
    output logic                  notWE,
    output logic                  notCS
);

    // Longest phase decides the counter width; counters hold (count - 1) and
    // are reloaded on every phase entry.
    localparam int MAX_PHASE_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_PHASE   = (MAX_PHASE_A > HOLD_CYCLES) ? MAX_PHASE_A : HOLD_CYCLES;
    localparam int CNT_W       = $clog2(MAX_PHASE) + 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef SRAM_CTRL_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_TURN  = 3'd4,
        ST_VCHK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  ncs_q, ncs_d;
    logic                  noe_q, noe_d;
    logic                  nwe_q, nwe_d;
    logic                  drive_q, drive_d;
`ifdef SRAM_CTRL_VERIFY_EN
    logic                  verr_q, verr_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. Strobes are decoded from the next
    // state so that the registered pins line up exactly with the state flops.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
        verr_d  = verr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (host.req) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    addr_d  = host.addrIn;
                    wdata_d = host.wdata;
                    we_d    = host.we;
                end
            end

            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_PULSE: begin
                if (cnt_q == '0) begin
                    // The SRAM is still driving the bus during this last
                    // PULSE cycle (notOE is low), so capture it here.
                    if (!we_q) begin
                        rdata_d = memData;
                    end
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_HOLD: begin
                if (cnt_q == '0) begin
`ifdef SRAM_CTRL_VERIFY_EN
                    if (we_q) begin
                        state_d = ST_TURN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        ack_d   = 1'b1;
                    end
`else
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

`ifdef SRAM_CTRL_VERIFY_EN
            // One dead cycle so the controller's write drivers are off before
            // the SRAM output is enabled for the read-back.
            ST_TURN: begin
                state_d = ST_VCHK;
                cnt_d   = PULSE_LOAD;
            end

            ST_VCHK: begin
                if (cnt_q == '0) begin
                    verr_d  = (memData != wdata_q);
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered pin values for the cycle about to start.
        ncs_d   = (state_d == ST_IDLE);
        nwe_d   = !((state_d == ST_PULSE) && we_d);
        noe_d   = !((state_d == ST_PULSE) && !we_d);
`ifdef SRAM_CTRL_VERIFY_EN
        if (state_d == ST_VCHK) begin
            noe_d = 1'b0;
        end
`endif
        drive_d = we_d && ((state_d == ST_SETUP) ||
                           (state_d == ST_PULSE) ||
                           (state_d == ST_HOLD));
        busy_d  = (state_d != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers, synchronous reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            ncs_q   <= 1'b1;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
            drive_q <= 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
            verr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            ncs_q   <= ncs_d;
            noe_q   <= noe_d;
            nwe_q   <= nwe_d;
            drive_q <= drive_d;
`ifdef SRAM_CTRL_VERIFY_EN
            verr_q  <= verr_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Pins and host outputs
    // -------------------------------------------------------------------------
    assign memAddr = addr_q;
    assign memData = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign notCS   = ncs_q;
    assign notOE   = noe_q;
    assign notWE   = nwe_q;

    assign host.ack       = ack_q;
    assign host.busy      = busy_q;
    assign host.rdata     = rdata_q;
    assign host.dbg_state = state_q;
    assign host.dbg_drive = drive_q;
`ifdef SRAM_CTRL_VERIFY_EN
    assign host.verifyErr = verr_q;
`else
    assign host.verifyErr = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
//   Directed bench for sram_ctrl. Instance A uses default timing (1/2/1),
//   instance B uses 2/3/2. Each instance talks to a small behavioural SRAM.
//   Cycle k is the clock period after rising edge k; a request sampled at
//   edge 0 is the reference for all latencies.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

`ifdef SRAM_CTRL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    // Expected latencies, derived from the phase lengths.
    localparam int LAT_A_R = 1 + 2 + 1 + 1;
    localparam int LAT_A_W = VERIFY ? (1 + 2 + 1 + 1 + 2 + 1) : LAT_A_R;
    localparam int LAT_B_R = 2 + 3 + 2 + 1;
    localparam int LAT_B_W = VERIFY ? (2 + 3 + 2 + 1 + 3 + 1) : LAT_B_R;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT A (default timing) ----------------
    sram_ctrl_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) a_if ();
    logic [3:0] ma_a;
    wire  [3:0] md_a;
    logic       noe_a, nwe_a, ncs_a;

    sram_ctrl #(
        .DATA_WIDTH(4), .ADDR_WIDTH(4),
        .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1)
    ) dut_a (
        .clk     (clk),
        .rst     (rst),
        .host    (a_if.slave),
        .memAddr (ma_a),
        .memData (md_a),
        .notOE   (noe_a),
        .notWE   (nwe_a),
        .notCS   (ncs_a)
    );

    // ---------------- DUT B (2/3/2 timing) ----------------
    sram_ctrl_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) b_if ();
    logic [3:0] ma_b;
    wire  [3:0] md_b;
    logic       noe_b, nwe_b, ncs_b;

    sram_ctrl #(
        .DATA_WIDTH(4), .ADDR_WIDTH(4),
        .SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(2)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .host    (b_if.slave),
        .memAddr (ma_b),
        .memData (md_b),
        .notOE   (noe_b),
        .notWE   (nwe_b),
        .notCS   (ncs_b)
    );

    // ---------------- SRAM models ----------------
    logic [3:0] mem_a [16];
    logic [3:0] mem_b [16];
    logic       force_on;
    logic [3:0] force_addr;

    assign md_a = (!ncs_a && !noe_a)
                ? ((force_on && (ma_a == force_addr)) ? 4'h7 : mem_a[ma_a])
                : 4'bz;
    assign md_b = (!ncs_b && !noe_b) ? mem_b[ma_b] : 4'bz;

    always @(posedge clk) begin
        if (!ncs_a && !nwe_a) mem_a[ma_a] <= md_a;
        if (!ncs_b && !nwe_b) mem_b[ma_b] <= md_b;
    end

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;
    int viol  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Continuous protocol rules on both instances.
    always @(negedge clk) begin
        if (!rst) begin
            if (!noe_a && !nwe_a) viol++;
            if (!noe_b && !nwe_b) viol++;
            if (!noe_a && a_if.dbg_drive) viol++;
            if (!noe_b && b_if.dbg_drive) viol++;
            if (ncs_a && a_if.dbg_drive) viol++;
            if (ncs_b && b_if.dbg_drive) viol++;
            if (a_if.busy !== !ncs_a) viol++;
            if (b_if.busy !== !ncs_b) viol++;
        end
    end

    // ---------------- observation mux for the access driver ----------------
    logic       sel;
    wire        o_ack   = sel ? b_if.ack       : a_if.ack;
    wire        o_busy  = sel ? b_if.busy      : a_if.busy;
    wire  [3:0] o_rdata = sel ? b_if.rdata     : a_if.rdata;
    wire        o_drive = sel ? b_if.dbg_drive : a_if.dbg_drive;
    wire        o_ncs   = sel ? ncs_b          : ncs_a;
    wire        o_noe   = sel ? noe_b          : noe_a;
    wire        o_nwe   = sel ? nwe_b          : nwe_a;
    wire  [3:0] o_maddr = sel ? ma_b           : ma_a;

    // One access on instance s. Entered and left at a falling edge; on return
    // the current cycle is the ack cycle.
    task automatic access(input logic s, input logic wr, input logic [3:0] addr,
                          input logic [3:0] data, input int exp_lat,
                          input int exp_p, input int exp_sph);
        int lat, we_low, oe_low, drv, cs_low, addr_bad;
        sel = s;
        if (s) begin
            b_if.req = 1'b1; b_if.we = wr; b_if.addrIn = addr; b_if.wdata = data;
        end else begin
            a_if.req = 1'b1; a_if.we = wr; a_if.addrIn = addr; a_if.wdata = data;
        end
        @(posedge clk);
        @(negedge clk);
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        lat = 0; we_low = 0; oe_low = 0; drv = 0; cs_low = 0; addr_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!o_ncs) begin
                cs_low++;
                if (o_maddr !== addr) addr_bad++;
            end
            if (!o_nwe) we_low++;
            if (!o_noe) oe_low++;
            if (o_drive) drv++;
            if (o_ack) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("lat_%s_%0h", wr ? "w" : "r", addr), lat, exp_lat);
        check("we_low_width", we_low, wr ? exp_p : 0);
        check("oe_low_width", oe_low, (wr && !VERIFY) ? 0 : exp_p);
        check("drive_cycles", drv, wr ? exp_sph : 0);
        check("cs_low_width", cs_low, exp_lat - 1);
        check("addr_stable", addr_bad, 0);
        check("busy_at_ack", o_busy, 1'b0);
        if (!wr) check($sformatf("rdata_%0h", addr), o_rdata, data);
    endtask

    // ---------------- main sequence ----------------
    int ack_cnt;
    int ack_cyc [4];

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        force_on = 1'b0;
        force_addr = 4'h0;
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addrIn = 4'h0; a_if.wdata = 4'h0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addrIn = 4'h0; b_if.wdata = 4'h0;
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_ncs", ncs_a, 1'b1);
        check("rst_noe", noe_a, 1'b1);
        check("rst_nwe", nwe_a, 1'b1);
        check("rst_ack", a_if.ack, 1'b0);
        check("rst_busy", a_if.busy, 1'b0);
        check("rst_rdata", a_if.rdata, 4'h0);
        check("rst_verr", a_if.verifyErr, 1'b0);
        check("rst_maddr", ma_a, 4'h0);
        check("rst_drive", a_if.dbg_drive, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Writes: data equals address.
        for (int a = 3; a <= 10; a++)
            access(1'b0, 1'b1, 4'(a), 4'(a), LAT_A_W, 2, 4);
        // Reads back.
        for (int a = 3; a <= 10; a++)
            access(1'b0, 1'b0, 4'(a), 4'(a), LAT_A_R, 2, 4);
        @(negedge clk);
        check("ack_one_cycle", a_if.ack, 1'b0);

        // A write must leave rdata alone.
        access(1'b0, 1'b1, 4'hB, 4'h1, LAT_A_W, 2, 4);
        check("rdata_hold_on_write", a_if.rdata, 4'hA);
        @(negedge clk);

        // req held for 12 edges with alternating we.
        a_if.req = 1'b1; a_if.addrIn = 4'hC; a_if.wdata = 4'hE;
        ack_cnt = 0;
        for (int e = 0; e < 24; e++) begin
            a_if.we  = (e % 2 == 0);
            a_if.req = (e < 12);
            @(negedge clk);
            if (a_if.ack) begin
                if (ack_cnt < 4) ack_cyc[ack_cnt] = e + 1;
                ack_cnt++;
            end
        end
`ifdef SRAM_CTRL_VERIFY_EN
        check("b2b_ack_count", ack_cnt, 2);
        check("b2b_ack0", ack_cyc[0], 8);
        check("b2b_ack1", ack_cyc[1], 16);
        check("b2b_rdata", a_if.rdata, 4'hA);
`else
        check("b2b_ack_count", ack_cnt, 3);
        check("b2b_ack0", ack_cyc[0], 5);
        check("b2b_ack1", ack_cyc[1], 10);
        check("b2b_ack2", ack_cyc[2], 15);
        check("b2b_rdata", a_if.rdata, 4'hE);
`endif

        // Reset during the second PULSE cycle of a write to 0x5.
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addrIn = 4'h5; a_if.wdata = 4'h9;
        @(posedge clk);
        @(negedge clk);                     // cycle 1: SETUP
        a_if.req = 1'b0;
        @(negedge clk);                     // cycle 2: PULSE 1
        @(negedge clk);                     // cycle 3: PULSE 2
        check("mid_pulse2_nwe", nwe_a, 1'b0);
        rst = 1'b1;
        @(negedge clk);                     // cycle 4: after reset edge
        check("mid_rst_ncs", ncs_a, 1'b1);
        check("mid_rst_noe", noe_a, 1'b1);
        check("mid_rst_nwe", nwe_a, 1'b1);
        check("mid_rst_busy", a_if.busy, 1'b0);
        check("mid_rst_ack", a_if.ack, 1'b0);
        check("mid_rst_rdata", a_if.rdata, 4'h0);
        check("mid_rst_maddr", ma_a, 4'h0);
        rst = 1'b0;
        ack_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_if.ack) ack_cnt++;
        end
        check("mid_rst_no_ack", ack_cnt, 0);

        // Instance B with stretched timing.
        access(1'b1, 1'b1, 4'h2, 4'h9, LAT_B_W, 3, 7);
        access(1'b1, 1'b0, 4'h2, 4'h9, LAT_B_R, 3, 7);
        @(negedge clk);

`ifdef SRAM_CTRL_VERIFY_EN
        // Read-back check: a location that returns 0x7 instead of 0x6.
        force_on = 1'b1; force_addr = 4'h6;
        access(1'b0, 1'b1, 4'h6, 4'h6, LAT_A_W, 2, 4);
        check("verify_err_set", a_if.verifyErr, 1'b1);
        force_on = 1'b0;
        access(1'b0, 1'b1, 4'h7, 4'h3, LAT_A_W, 2, 4);
        check("verify_err_clear", a_if.verifyErr, 1'b0);
`else
        check("verify_err_tied", a_if.verifyErr, 1'b0);
`endif

        repeat (2) @(negedge clk);
        check("protocol_violations", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
